dmem_arbiter: RTL and testbench

//  Shares the single-port data RAM (sp_ram data instance) between the core LSU (port 0) and a

---
 rtl/dmem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the core LSU (port 0)
// and a loader/debug master (port 1). Grants are combinational and only one
// port is granted per cycle. Every grant produces exactly one response one
// cycle later. Out-of-range accesses never reach the RAM; they are answered
// locally with err=1.
// Compile-time option: define DMEM_ARB_RR_EN for round-robin arbitration.
// Without it, port 0 has fixed priority. In both modes, a starvation guard
// forces a grant to a port that has waited MAX_WAIT cycles.
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int MAX_WAIT   = 15
) (
   input  logic                         clk,
   input  logic                         rst_n,
   // port 0: core LSU
   input  logic                         m0_req,
   input  logic                         m0_we,
   input  logic [DATA_WIDTH/8-1:0]      m0_be,
   input  logic [ADDR_WIDTH-1:0]        m0_addr,
   input  logic [DATA_WIDTH-1:0]        m0_wdata,
   output logic                         m0_gnt,
   output logic                         m0_rvalid,
   output logic [DATA_WIDTH-1:0]        m0_rdata,
   output logic                         m0_err,
   // port 1: loader / debug master
   input  logic                         m1_req,
   input  logic                         m1_we,
   input  logic [DATA_WIDTH/8-1:0]      m1_be,
   input  logic [ADDR_WIDTH-1:0]        m1_addr,
   input  logic [DATA_WIDTH-1:0]        m1_wdata,
   output logic                         m1_gnt,
   output logic                         m1_rvalid,
   output logic [DATA_WIDTH-1:0]        m1_rdata,
   output logic                         m1_err,
   // RAM side
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [DATA_WIDTH/8-1:0]      mem_be,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]        mem_wdata,
   input  logic [DATA_WIDTH-1:0]        mem_rdata
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int MEM_AW   = $clog2(MEM_WORDS);
   localparam int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CNT_W-1:0]      WAIT_MAX   = CNT_W'(MAX_WAIT);
   // one bit wider than the address so the limit itself is representable
   localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS * 4);

   // per-port views so the per-port logic can be generated
   logic [1:0]            req_vec;
   logic [1:0]            we_vec;
   logic [BE_WIDTH-1:0]   be_vec    [2];
   logic [ADDR_WIDTH-1:0] addr_vec  [2];
   logic [DATA_WIDTH-1:0] wdata_vec [2];

   assign req_vec      = {m1_req, m0_req};
   assign we_vec       = {m1_we, m0_we};
   assign be_vec[0]    = m0_be;
   assign be_vec[1]    = m1_be;
   assign addr_vec[0]  = m0_addr;
   assign addr_vec[1]  = m1_addr;
   assign wdata_vec[0] = m0_wdata;
   assign wdata_vec[1] = m1_wdata;

   logic [1:0] starve;     // port requesting and has waited MAX_WAIT cycles
   logic [1:0] in_range;   // port address falls inside the RAM
   logic [1:0] gnt_vec;    // one-hot (or zero) grant

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [CNT_W-1:0] wait_cnt_reg;

         assign starve[gi]   = req_vec[gi] && (wait_cnt_reg == WAIT_MAX);
         assign in_range[gi] = ({1'b0, addr_vec[gi]} < ADDR_LIMIT);

         // Starvation counter: counts denied request cycles, saturates, clears on grant or idle
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wait_cnt_reg <= '0;
            end else if (gnt_vec[gi] || !req_vec[gi]) begin
               wait_cnt_reg <= '0;
            end else if (wait_cnt_reg != WAIT_MAX) begin
               wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
         end
      end
   endgenerate

`ifdef DMEM_ARB_RR_EN
   logic last_owner_reg;

   // Remember which port was granted last so a tie goes to the other port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner_reg <= 1'b1;
      end else if (|gnt_vec) begin
         last_owner_reg <= gnt_vec[1];
      end
   end
`endif

   // Grant selection: starvation guard first (port 0 wins a double starve), then the base policy
   always_comb begin
      gnt_vec = 2'b00;
      if (!rst_n) begin
         gnt_vec = 2'b00;
      end else if (starve[0]) begin
         gnt_vec = 2'b01;
      end else if (starve[1]) begin
         gnt_vec = 2'b10;
      end else begin
`ifdef DMEM_ARB_RR_EN
         if (req_vec == 2'b11) begin
            gnt_vec = last_owner_reg ? 2'b01 : 2'b10;
         end else begin
            gnt_vec = req_vec;
         end
`else
         if (req_vec[0]) begin
            gnt_vec = 2'b01;
         end else if (req_vec[1]) begin
            gnt_vec = 2'b10;
         end
`endif
      end
   end

   assign m0_gnt = gnt_vec[0];
   assign m1_gnt = gnt_vec[1];

   logic                  grant_any;
   logic                  sel;
   logic                  sel_in_range;
   logic                  sel_we;
   logic [BE_WIDTH-1:0]   sel_be;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   assign grant_any    = |gnt_vec;
   assign sel          = gnt_vec[1];
   assign sel_in_range = in_range[sel];
   assign sel_we       = we_vec[sel];
   assign sel_be       = be_vec[sel];
   assign sel_addr     = addr_vec[sel];
   assign sel_wdata    = wdata_vec[sel];

   // RAM request: forward the granted payload only when the access is in range; otherwise drive zeros
   always_comb begin
      mem_req   = grant_any && sel_in_range;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (mem_req) begin
         mem_we    = sel_we;
         mem_be    = sel_be;
         mem_addr  = sel_addr[MEM_AW+1:2];
         mem_wdata = sel_wdata;
      end
   end

   logic rsp_valid_reg;
   logic rsp_owner_reg;
   logic rsp_err_reg;
   logic rsp_we_reg;

   // Response pipe: capture who was granted and how the access must be answered next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_reg <= 1'b0;
         rsp_owner_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_we_reg    <= 1'b0;
      end else begin
         rsp_valid_reg <= grant_any;
         rsp_owner_reg <= sel;
         rsp_err_reg   <= grant_any && !sel_in_range;
         rsp_we_reg    <= sel_we;
      end
   end

   logic [DATA_WIDTH-1:0] rsp_data;

   // Response steering: only successful loads return RAM data; stores and errors return zero
   always_comb begin
      rsp_data  = '0;
      m0_rvalid = rsp_valid_reg && !rsp_owner_reg;
      m1_rvalid = rsp_valid_reg && rsp_owner_reg;
      m0_err    = m0_rvalid && rsp_err_reg;
      m1_err    = m1_rvalid && rsp_err_reg;
      if (rsp_valid_reg && !rsp_err_reg && !rsp_we_reg) begin
         rsp_data = mem_rdata;
      end
      m0_rdata  = m0_rvalid ? rsp_data : '0;
      m1_rdata  = m1_rvalid ? rsp_data : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// 1-cycle-latency RAM and a response scoreboard. Define DMEM_ARB_RR_EN here
// as well when building the round-robin variant.
module tb_dmem_arbiter;

   localparam int MEM_WORDS = 1024;
   localparam int MEM_BYTES = MEM_WORDS * 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [3:0]  m0_be, m1_be;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int gcnt0  = 0;
   int gcnt1  = 0;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] ref_mem [MEM_WORDS];
   logic [31:0] ram     [MEM_WORDS];
   logic        ram_ready = 1'b0;

   dmem_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MEM_WORDS), .MAX_WAIT(15)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_val(input int i);
      if (i == 4) return 32'hCAFEF00D;
      if (i == 8) return 32'hAABBCCDD;
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // behavioural single-port RAM, 1-cycle read latency, byte-enabled writes
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < MEM_WORDS; i++) ram[i] <= init_val(i);
         ram_ready <= 1'b1;
      end else if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
         mem_rdata <= ram[mem_addr];
      end
   end

   // a pending response is discarded by reset
   always @(negedge rst_n) sb_q.delete();

   // monitor: match responses against the scoreboard, then log new grants
   always @(negedge clk) begin : mon
      exp_t        e;
      int          p;
      logic [31:0] a, wd, old, exp_d;
      logic [3:0]  be;
      logic        we, inr;
      if (rst_n) begin
         if (m0_rvalid || m1_rvalid) begin
            if (sb_q.size() == 0) begin
               check("rvalid_without_grant", {m1_rvalid, m0_rvalid}, 32'h0);
            end else begin
               e = sb_q.pop_front();
               check("rsp_port", {m1_rvalid, m0_rvalid}, (e.port == 1) ? 32'h2 : 32'h1);
               check("rsp_rdata", m1_rvalid ? m1_rdata : m0_rdata, e.rdata);
               check("rsp_err", {m1_err, m0_err}, e.err ? ((e.port == 1) ? 32'h2 : 32'h1) : 32'h0);
            end
         end else if (sb_q.size() != 0) begin
            check("rvalid_missing", 32'(m0_rvalid | m1_rvalid), 32'h1);
            void'(sb_q.pop_front());
         end

         check("gnt_exclusive", 32'(m0_gnt & m1_gnt), 32'h0);
         if (m0_gnt || m1_gnt) begin
            p   = m1_gnt ? 1 : 0;
            a   = p ? m1_addr  : m0_addr;
            wd  = p ? m1_wdata : m0_wdata;
            be  = p ? m1_be    : m0_be;
            we  = p ? m1_we    : m0_we;
            inr = (a < MEM_BYTES);
            if (p == 1) gcnt1++; else gcnt0++;
            check("mem_req_on_gnt", 32'(mem_req), 32'(inr));
            exp_d = 32'h0;
            if (inr) begin
               check("mem_addr", 32'(mem_addr), 32'(a[11:2]));
               check("mem_we", 32'(mem_we), 32'(we));
               if (we) begin
                  check("mem_be", 32'(mem_be), 32'(be));
                  check("mem_wdata", mem_wdata, wd);
                  old = ref_mem[a[11:2]];
                  for (int b = 0; b < 4; b++)
                     if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
                  ref_mem[a[11:2]] = old;
               end else begin
                  exp_d = ref_mem[a[11:2]];
               end
            end
            e.port  = p;
            e.rdata = exp_d;
            e.err   = !inr;
            sb_q.push_back(e);
         end else begin
            check("idle_mem_req", {mem_req, mem_we, mem_be}, 32'h0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (p == 0) begin
         m0_req = 1'b1; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = 1'b1; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   task automatic release_port(input int p);
      if (p == 0) begin
         m0_req = 1'b0; m0_we = 1'b0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
      end else begin
         m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
      end
   endtask

   // returns at the falling edge of the cycle in which port p is granted
   task automatic wait_gnt(input int p);
      int n = 0;
      @(negedge clk);
      while (((p == 0) ? m0_gnt : m1_gnt) !== 1'b1 && n < 64) begin
         n++;
         @(negedge clk);
      end
      check("gnt_timeout", 32'((p == 0) ? m0_gnt : m1_gnt), 32'h1);
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
                  mem_req, mem_we, mem_be}, 32'h0);
      check({tag, "_rdata"}, m0_rdata | m1_rdata, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] gv, prev;
      int         c0, g0;

      rst_n = 1'b0;
      release_port(0);
      release_port(1);
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset_outputs");
      #2 rst_n = 1'b1;

      // T1: single load
      step();
      drive(0, 1'b0, 4'hF, 32'h10, 32'h0);
      wait_gnt(0);
      step();
      release_port(0);
      @(negedge clk);
      check("t1_rvalid", 32'(m0_rvalid), 32'h1);
      check("t1_rdata", m0_rdata, 32'hCAFEF00D);
      check("t1_err", 32'(m0_err), 32'h0);

      // T2: partial store followed by load of the same word
      step();
      drive(1, 1'b1, 4'b0011, 32'h20, 32'h11223344);
      wait_gnt(1);
      step();
      drive(1, 1'b0, 4'hF, 32'h20, 32'h0);
      @(negedge clk);
      check("t2_store_rvalid", 32'(m1_rvalid), 32'h1);
      check("t2_store_rdata", m1_rdata, 32'h0);
      check("t2_load_gnt", 32'(m1_gnt), 32'h1);
      step();
      release_port(1);
      @(negedge clk);
      check("t2_load_rvalid", 32'(m1_rvalid), 32'h1);
      check("t2_load_rdata", m1_rdata, 32'hAABB3344);

      // T3: continuous contention for 40 cycles
      step();
      drive(0, 1'b0, 4'hF, 32'h10, 32'h0);
      drive(1, 1'b0, 4'hF, 32'h24, 32'h0);
      prev = 2'b00;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         gv = {m1_gnt, m0_gnt};
         check("t3_single_grant", 32'($onehot(gv)), 32'h1);
`ifdef DMEM_ARB_RR_EN
         if (c > 0) check("t3_alternate", 32'(gv), 32'({prev[0], prev[1]}));
`else
         check("t3_fixed_grant", 32'(gv), ((c % 16) == 15) ? 32'h2 : 32'h1);
`endif
         prev = gv;
      end
      step();
      release_port(0);
      release_port(1);
      repeat (2) @(negedge clk);

      // T4: out-of-range load
      step();
      drive(0, 1'b0, 4'hF, 32'h1000, 32'h0);
      @(negedge clk);
      check("t4_gnt", 32'(m0_gnt), 32'h1);
      check("t4_mem_req", 32'(mem_req), 32'h0);
      step();
      release_port(0);
      @(negedge clk);
      check("t4_rvalid", 32'(m0_rvalid), 32'h1);
      check("t4_err", 32'(m0_err), 32'h1);
      check("t4_rdata", m0_rdata, 32'h0);

      // T5: reset between grant and response
      step();
      drive(0, 1'b0, 4'hF, 32'h10, 32'h0);
      @(negedge clk);
      check("t5_gnt", 32'(m0_gnt), 32'h1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("t5_in_reset");
      step();
      release_port(0);
      @(negedge clk);
      check("t5_no_rvalid_in_reset", 32'(m0_rvalid), 32'h0);
      check_all_zero("t5_held_reset");
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("t5_no_rvalid_after", 32'(m0_rvalid), 32'h0);

      // T6: loader preload of words 0..255, then core readback
      step();
      c0 = cyc;
      g0 = gcnt1;
      for (int i = 0; i < 256; i++) begin
         drive(1, 1'b1, 4'hF, 32'(i * 4), 32'(i));
         @(negedge clk);
         check("t6_store_gnt", 32'(m1_gnt), 32'h1);
         step();
      end
      release_port(1);
      check("t6_grant_count", 32'(gcnt1 - g0), 32'd256);
      check("t6_cycle_count", 32'(cyc - c0), 32'd256);
      for (int i = 0; i < 256; i++) begin
         drive(0, 1'b0, 4'hF, 32'(i * 4), 32'h0);
         @(negedge clk);
         check("t6_load_gnt", 32'(m0_gnt), 32'h1);
         if (i > 0) check("t6_readback", m0_rdata, 32'(i - 1));
         step();
      end
      release_port(0);
      @(negedge clk);
      check("t6_readback_last", m0_rdata, 32'd255);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
